// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - register-file writeback merge of ALU results and load returns
//
// Purpose:
//   Owns the single write port of the register file. ALU results are written
//   one cycle after they arrive. Load returns are always queued in a small
//   FIFO and drained whenever the ALU leaves the write port free. An optional
//   per-register pending-load scoreboard is built when WB_SCOREBOARD_EN is
//   defined; otherwise pending is tied to zero.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   alu_valid/alu_reg/alu_data        single-cycle ALU result
//   mem_valid/mem_reg/mem_data        load return, accepted on mem_valid && mem_ready
//   mem_ready                         FIFO has room (from registered count)
//   issue_valid/issue_reg             load issued (scoreboard set)
//   reg_write/write_reg/write_data    registered register-file write
//   pending                           bit i = load to register i outstanding
//   fifo_count                        load FIFO occupancy
//
// Build option: WB_SCOREBOARD_EN

module reg_wb_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    assign head_reg  = reg_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module reg_writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       mem_ready,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_reg,
    output logic                       reg_write,
    output logic [ADDR_W-1:0]          write_reg,
    output logic [DATA_W-1:0]          write_data,
    output logic [15:0]                pending,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_sel;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    // Full means not ready even if a pop happens this cycle.
    assign mem_ready = (fifo_count < CW'(DEPTH));
    assign alu_sel   = alu_valid && (alu_reg != '0);
    // An ALU write to r_0 does not occupy the port, so the FIFO may drain.
    assign pop       = !alu_sel && (fifo_count != '0);
    // Loads to r_0 complete the handshake but are never stored.
    assign push      = mem_valid && mem_ready && (mem_reg != '0);

    reg_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CW     (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (mem_reg),
        .push_data (mem_data),
        .pop       (pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (fifo_count)
    );

    // Index and data hold their last values on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (alu_sel) begin
            reg_write  <= 1'b1;
            write_reg  <= alu_reg;
            write_data <= alu_data;
        end else if (pop) begin
            reg_write  <= 1'b1;
            write_reg  <= head_reg;
            write_data <= head_data;
        end else begin
            reg_write  <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] pending_q;

    assign set_vec = (issue_valid && issue_reg != '0) ? (16'h0001 << issue_reg) : 16'h0000;
    assign clr_vec = pop ? (16'h0001 << head_reg) : 16'h0000;

    // Clear first, then set, so an issue on the popping edge keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 16'h0000;
        end else begin
            pending_q <= ((pending_q & ~clr_vec) | set_vec) & 16'hFFFE;
        end
    end

    assign pending = pending_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_reg};
    assign pending      = 16'h0000;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_reg = '0;
    logic [15:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_reg = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_reg = '0;
    logic        reg_write;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic [15:0] pending;
    logic [2:0]  fifo_count;

    reg_writeback_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .pending     (pending),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue of loads plus expected port values.
    logic [3:0]  mq_reg[$];
    logic [15:0] mq_data[$];
    logic        exp_we   = 1'b0;
    logic [3:0]  exp_reg  = '0;
    logic [15:0] exp_data = '0;
    logic [15:0] exp_pend = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".reg_write"},  32'(reg_write),  32'(exp_we));
        chk({tag, ".write_reg"},  32'(write_reg),  32'(exp_reg));
        chk({tag, ".write_data"}, 32'(write_data), 32'(exp_data));
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(mq_reg.size()));
        chk({tag, ".pending"},    32'(pending),    32'(exp_pend));
    endtask

    task automatic step(input string tag,
                        input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic mv, input logic [3:0] mr, input logic [15:0] md,
                        input logic iv, input logic [3:0] ir);
        logic ready;
        @(negedge clk);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        issue_valid = iv; issue_reg = ir;
        ready = (mq_reg.size() < DEPTH);
        chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(ready));
        if (av && ar != 0) begin
            exp_we = 1'b1; exp_reg = ar; exp_data = ad;
        end else if (mq_reg.size() > 0) begin
            exp_we = 1'b1; exp_reg = mq_reg.pop_front(); exp_data = mq_data.pop_front();
`ifdef WB_SCOREBOARD_EN
            exp_pend[exp_reg] = 1'b0;
`endif
        end else begin
            exp_we = 1'b0;
        end
        if (mv && ready && mr != 0) begin
            mq_reg.push_back(mr);
            mq_data.push_back(md);
        end
`ifdef WB_SCOREBOARD_EN
        if (iv && ir != 0) exp_pend[ir] = 1'b1;
`endif
        @(posedge clk);
        #1;
        chk_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state while rst is held.
        #2;
        chk_outputs("reset");
        chk("reset.mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle("post_reset");

        // 1. ALU only.
        step("alu_only", 1, 3, 16'hBEEF, 0, 0, 0, 0, 0);
        chk("alu_only.data_const", 32'(write_data), 32'h0000BEEF);
        idle("alu_only_idle");

        // 2. Collision: ALU first, load on the following cycle.
        step("collide0", 1, 2, 16'h0011, 1, 5, 16'h0055, 0, 0);
        chk("collide0.count1", 32'(fifo_count), 32'd1);
        idle("collide1");
        chk("collide1.r5", 32'({reg_write, write_reg, write_data}), 32'h15_0055);
        idle("collide2");

        // 3. Fill the FIFO under a busy ALU, then drain; 5th load held until room.
        for (int i = 0; i < 4; i++)
            step("fill", 1, 1, 16'(i), 1, 4'(8 + i), 16'(16'h0080 + i), 0, 0);
        chk("fill.count4", 32'(fifo_count), 32'd4);
        step("fill_full", 1, 1, 16'h00AA, 1, 12, 16'h00C0, 0, 0);
        chk("fill_full.ready0", 32'(mem_ready), 32'd0);
        for (int i = 0; i < 3; i++)
            step("drain_hold", 0, 0, 0, 1, 12, 16'h00C0, 0, 0);
        for (int i = 0; i < 4; i++) idle("drain");

        // 4. r_0 handling: ALU to r_0 does not block the pop; load to r_0 dropped.
        step("r0_push", 1, 1, 16'h1111, 1, 7, 16'h0007, 0, 0);
        step("r0_alu", 1, 0, 16'hDEAD, 1, 0, 16'h9999, 0, 0);
        chk("r0_alu.r7", 32'({reg_write, write_reg, write_data}), 32'h17_0007);
        idle("r0_after");
        idle("r0_after2");

        // 5. Scoreboard set/clear and set-wins.
        step("sb_issue", 0, 0, 0, 0, 0, 0, 1, 4);
        step("sb_ret", 0, 0, 0, 1, 4, 16'h0444, 0, 0);
        step("sb_pop", 0, 0, 0, 0, 0, 0, 0, 0);
        step("sb_issue2", 0, 0, 0, 0, 0, 0, 1, 4);
        step("sb_ret2", 0, 0, 0, 1, 4, 16'h0445, 0, 0);
        step("sb_popset", 0, 0, 0, 0, 0, 0, 1, 4);
`ifdef WB_SCOREBOARD_EN
        chk("sb_popset.const", 32'(pending), 32'h0010);
`else
        chk("sb_popset.const", 32'(pending), 32'h0000);
`endif
        step("sb_r0", 0, 0, 0, 0, 0, 0, 1, 0);

        // 6. Reset with queued entries and pending bits.
        for (int i = 0; i < 4; i++)
            step("pre_rst", 1, 1, 16'h2222, (i < 3), 4'(4 + i), 16'(16'h0700 + i), 1, 4'(4 + i));
        @(negedge clk);
        rst = 1'b1;
        #1;
        mq_reg.delete(); mq_data.delete();
        exp_we = 1'b0; exp_reg = '0; exp_data = '0; exp_pend = '0;
        chk_outputs("async_rst");
        @(negedge clk);
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        rst = 1'b0;
        #1;
        chk("rst_release.ready", 32'(mem_ready), 32'd1);
        for (int i = 0; i < 3; i++) idle("rst_nowrite");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 6; i++) idle("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
